// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, sequencer states and size helpers for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        WAIT1,
        REQ2,
        WAIT2,
        DONE
    } lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_merge.sv
// rtl/lsu_merge.sv - aligns the one or two returned beats and extends the load result
module lsu_merge
    import lsu_pkg::*;
(
    input  logic [31:0] i_beat1,
    input  logic [31:0] i_beat2,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load_data
);

    logic [31:0] w_word;

    assign w_word = 32'({i_beat2, i_beat1} >> {i_off, 3'b000});

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_word[7]}}, w_word[7:0]};
            F3_LH:   o_load_data = {{16{w_word[15]}}, w_word[15:0]};
            F3_LW:   o_load_data = w_word;
            F3_LBU:  o_load_data = {24'b0, w_word[7:0]};
            F3_LHU:  o_load_data = {16'b0, w_word[15:0]};
            default: o_load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer stalling M while a memory access is in flight
// Two-beat misaligned accesses are built only when LSU_MISALIGNED_SPLIT_EN is defined.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] load_data,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  r_state;
    logic [15:0] r_cnt;
    logic [29:0] r_word;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic        r_we;
    logic        r_err;
    logic [7:0]  r_strb;
    logic [63:0] r_wdata;
    logic [31:0] r_beat1;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic        r_split;
    logic [31:0] r_beat2;
`endif

    logic        w_access;
    logic        w_split;
    logic        w_reject;
    logic        w_timeout;
    logic        w_in_flight;
    logic        w_advance;
    lsu_state_t  w_next;
    logic [7:0]  w_strb;
    logic [63:0] w_wdata;
    logic [31:0] w_beat2;
    logic [31:0] w_merged;

    // Strobes and data are laid out across two words; the upper half is beat 2.
    assign w_access  = MemReadM | MemWriteM;
    assign w_strb    = {4'b0000, size_mask(funct3M)} << ALUResultM[1:0];
    assign w_split   = |w_strb[7:4];
    assign w_wdata   = {32'b0, WriteDataM} << {ALUResultM[1:0], 3'b000};
    assign w_timeout = (r_cnt == 16'(MAX_WAIT - 1));

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign w_reject = !is_legal(funct3M);
    assign w_beat2  = r_beat2;
`else
    assign w_reject = !is_legal(funct3M) | w_split;
    assign w_beat2  = '0;
`endif

    always_comb begin
        w_advance = 1'b0;
        w_next    = r_state;
        case (r_state)
            REQ1: begin
                w_advance = mem_gnt;
                w_next    = WAIT1;
            end
            WAIT1: begin
                w_advance = mem_rvalid;
                w_next    = DONE;
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (r_split) w_next = REQ2;
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            REQ2: begin
                w_advance = mem_gnt;
                w_next    = WAIT2;
            end
            WAIT2: begin
                w_advance = mem_rvalid;
                w_next    = DONE;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_off   <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_strb  <= '0;
            r_wdata <= '0;
            r_beat1 <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_split <= 1'b0;
            r_beat2 <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_cnt   <= '0;
                        r_beat1 <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        r_beat2 <= '0;
                        r_split <= w_split;
`endif
                        if (w_reject) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_word  <= ALUResultM[31:2];
                            r_off   <= ALUResultM[1:0];
                            r_f3    <= funct3M;
                            r_we    <= MemWriteM;
                            r_strb  <= MemWriteM ? w_strb : '0;
                            r_wdata <= MemWriteM ? w_wdata : '0;
                            r_err   <= 1'b0;
                            r_state <= REQ1;
                        end
                    end
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    // Progress wins over a timeout landing in the same cycle.
                    if (w_advance) begin
                        r_state <= w_next;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= DONE;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    if (r_state == WAIT1 && mem_rvalid) r_beat1 <= mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (r_state == WAIT2 && mem_rvalid) r_beat2 <= mem_rdata;
`endif
                end
            endcase
        end
    end

    lsu_merge u_merge (
        .i_beat1     (r_beat1),
        .i_beat2     (w_beat2),
        .i_off       (r_off),
        .i_funct3    (r_f3),
        .o_load_data (w_merged)
    );

    assign w_in_flight = (r_state == REQ1) || (r_state == WAIT1) ||
                         (r_state == REQ2) || (r_state == WAIT2);

    // rst_n gate keeps StallM low while reset is held even if M still shows an access.
    assign StallM    = w_in_flight | (rst_n & (r_state == IDLE) & w_access);
    assign mem_req   = (r_state == REQ1) || (r_state == REQ2);
    assign mem_we    = mem_req & r_we;
    assign mem_addr  = (r_state == REQ1) ? {r_word, 2'b00} :
                       (r_state == REQ2) ? {r_word + 30'd1, 2'b00} : '0;
    assign mem_wstrb = (r_state == REQ1) ? r_strb[3:0] :
                       (r_state == REQ2) ? r_strb[7:4] : '0;
    assign mem_wdata = (r_state == REQ1) ? r_wdata[31:0] :
                       (r_state == REQ2) ? r_wdata[63:32] : '0;
    assign lsu_err   = (r_state == DONE) & r_err;
    assign load_data = ((r_state == DONE) && !r_err && !r_we) ? w_merged : '0;

endmodule
